// File: rtl/cpu_pkg.sv
// Shared writeback types: register-file width, the SP/XZR register index
// and the request record carried by both result sources and the load FIFO.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam logic [4:0] REG_SP_XZR = 5'd31;

    typedef struct packed {
        logic [4:0]      rd;
        logic            use_sp;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // rd=31 addressed as the zero register: the write is discarded.
    function automatic logic is_xzr(input wb_req_t req);
        return (req.rd == REG_SP_XZR) && !req.use_sp;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers for full/empty.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push is accepted when not full, or when full with a pop in the same cycle.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read once the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: ALU results win, queued loads fill gaps, forced drain on starvation.
// Latency: selected in cycle N, on the write port in N+1; load enqueue to RegWrite is 2 cycles minimum.
// Backpressure: ld_ready drops when the load FIFO is full; alu_stall pauses the ALU for one cycle.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic            alu_use_sp,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic            ld_use_sp,
    input  logic [XLEN-1:0] ld_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            issue_use_sp,
    output logic [31:0]     busy,
    output logic            RegWrite,
    output logic [4:0]      Write_register,
    output logic [XLEN-1:0] Write_d,
    output logic            proto_err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(STARVE_LIMIT);

    wb_req_t       alu_req;
    wb_req_t       ld_req;
    wb_req_t       head_req;
    wb_req_t       sel_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic          enq;
    logic          alu_sel;
    logic          ld_sel;
    logic          any_sel;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;
    logic          clr_vld;
    logic [4:0]    clr_rd;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    assign alu_req = '{rd: alu_rd, use_sp: alu_use_sp, data: alu_data};
    assign ld_req  = '{rd: ld_rd,  use_sp: ld_use_sp,  data: ld_data};

    assign ld_ready = !fifo_full;
    assign enq      = ld_valid && !fifo_full;

    wb_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (enq),
        .push_dat (ld_req),
        .pop_vld  (ld_sel),
        .head_dat (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // During a forced drain the ALU slot is ignored, so the FIFO head takes it.
    assign alu_sel = alu_valid && !alu_stall;
    assign ld_sel  = !alu_sel && !fifo_empty;
    assign any_sel = alu_sel || ld_sel;
    assign sel_req = alu_sel ? alu_req : head_req;

    assign starve_nxt = (alu_sel && !fifo_empty) ? starve_cnt + CNT_ONE : '0;

    assign set_mask = (issue_valid && !(issue_rd == REG_SP_XZR && !issue_use_sp))
                      ? (32'd1 << issue_rd) : 32'd0;
    assign clr_mask = clr_vld ? (32'd1 << clr_rd) : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt     <= '0;
            alu_stall      <= 1'b0;
            proto_err      <= 1'b0;
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_d        <= '0;
            clr_vld        <= 1'b0;
            clr_rd         <= '0;
            busy           <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            alu_stall  <= (starve_nxt == CNT_LIMIT);
            proto_err  <= proto_err | (alu_valid & alu_stall);
            RegWrite   <= any_sel && !is_xzr(sel_req);
            if (any_sel) begin
                Write_register <= sel_req.rd;
                Write_d        <= sel_req.data;
            end
            // A dequeued load is on the port next cycle; its pending bit drops at the end of that cycle.
            clr_vld <= ld_sel;
            clr_rd  <= head_req.rd;
            busy    <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed plus randomized check of reg_writeback against a queue-based model.
module tb_reg_writeback;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic        alu_use_sp;
    logic [63:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic        ld_use_sp;
    logic [63:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_use_sp;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [63:0] Write_d;
    logic        proto_err;

    reg_writeback dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_use_sp     (alu_use_sp),
        .alu_data       (alu_data),
        .alu_stall      (alu_stall),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_use_sp      (ld_use_sp),
        .ld_data        (ld_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_use_sp   (issue_use_sp),
        .busy           (busy),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_d        (Write_d),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: pending loads as a queue, pending registers as a bit array.
    typedef struct {
        logic [4:0]  rd;
        logic        sp;
        logic [63:0] d;
    } res_t;

    res_t        q[$];
    int          streak;
    bit          m_stall;
    bit          m_perr;
    bit          m_we;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;
    bit          m_busy[32];
    bit          pend_clr;
    logic [4:0]  pend_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        streak   = 0;
        m_stall  = 0;
        m_perr   = 0;
        m_we     = 0;
        m_wr     = '0;
        m_wd     = '0;
        pend_clr = 0;
        pend_rd  = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    task automatic check_all();
        chk("regwrite", {63'd0, RegWrite}, {63'd0, m_we});
        if (m_we) begin
            chk("write_register", {59'd0, Write_register}, {59'd0, m_wr});
            chk("write_d", Write_d, m_wd);
        end
        chk("busy", {32'd0, busy}, {32'd0, busy_vec()});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, (q.size() < 4)});
        chk("alu_stall", {63'd0, alu_stall}, {63'd0, m_stall});
        chk("proto_err", {63'd0, proto_err}, {63'd0, m_perr});
    endtask

    // Apply this cycle's inputs to the model, producing the state seen after the edge.
    task automatic model_cycle();
        int   sz0;
        bit   alu_wins;
        bit   take_ld;
        res_t w;
        sz0      = q.size();
        alu_wins = alu_valid && !m_stall;
        take_ld  = !alu_wins && (sz0 > 0);
        w        = '{rd: 5'd0, sp: 1'b0, d: 64'd0};
        if (pend_clr) m_busy[pend_rd] = 0;
        if (issue_valid && !(issue_rd == 5'd31 && !issue_use_sp)) m_busy[issue_rd] = 1;
        if (alu_wins)     w = '{rd: alu_rd, sp: alu_use_sp, d: alu_data};
        else if (take_ld) w = q.pop_front();
        pend_clr = take_ld;
        pend_rd  = w.rd;
        m_we     = (alu_wins || take_ld) && !(w.rd == 5'd31 && !w.sp);
        if (alu_wins || take_ld) begin
            m_wr = w.rd;
            m_wd = w.d;
        end
        if (alu_valid && m_stall) m_perr = 1;
        streak  = (alu_wins && sz0 > 0) ? streak + 1 : 0;
        m_stall = (streak == 8);
        if (ld_valid && sz0 < 4) q.push_back('{rd: ld_rd, sp: ld_use_sp, d: ld_data});
    endtask

    task automatic tick();
        check_all();
        model_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid   = 0;
        ld_valid    = 0;
        issue_valid = 0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic sp, input logic [63:0] d);
        alu_valid = 1; alu_rd = rd; alu_use_sp = sp; alu_data = d;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic sp, input logic [63:0] d);
        ld_valid = 1; ld_rd = rd; ld_use_sp = sp; ld_data = d;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic sp);
        issue_valid = 1; issue_rd = rd; issue_use_sp = sp;
    endtask

    task automatic random_cycle(input int alu_pct);
        logic [4:0] r;
        idle();
        r = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 99) < alu_pct) set_alu(r, 1'($urandom), {$urandom, $urandom});
        r = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) set_ld(r, 1'($urandom), {$urandom, $urandom});
        r = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        if ($urandom_range(0, 2) == 0) set_issue(r, 1'($urandom));
        tick();
    endtask

    initial begin
        reset_n = 0;
        alu_rd = '0; alu_use_sp = 0; alu_data = '0;
        ld_rd = '0; ld_use_sp = 0; ld_data = '0;
        issue_rd = '0; issue_use_sp = 0;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("reset_write_register", {59'd0, Write_register}, 64'd0);
        chk("reset_write_d", Write_d, 64'd0);
        reset_n = 1;

        // Single ALU write, one-cycle latency.
        set_alu(5'd5, 0, 64'h1234);
        tick();
        idle();
        chk("alu_we", {63'd0, RegWrite}, 64'd1);
        chk("alu_wr", {59'd0, Write_register}, 64'd5);
        chk("alu_wd", Write_d, 64'h1234);
        tick();
        chk("alu_we_off", {63'd0, RegWrite}, 64'd0);

        // Load to x7 with scoreboard tracking.
        set_issue(5'd7, 0);
        tick();
        idle();
        chk("busy7_set", {63'd0, busy[7]}, 64'd1);
        set_ld(5'd7, 0, 64'hAA);
        tick();
        idle();
        chk("ld_not_yet", {63'd0, RegWrite}, 64'd0);
        tick();
        chk("ld_we", {63'd0, RegWrite}, 64'd1);
        chk("ld_wr", {59'd0, Write_register}, 64'd7);
        chk("ld_wd", Write_d, 64'hAA);
        chk("busy7_during_write", {63'd0, busy[7]}, 64'd1);
        tick();
        chk("busy7_clear", {63'd0, busy[7]}, 64'd0);

        // Fill the FIFO under constant ALU traffic, then forced drain and protocol error.
        for (int i = 0; i < 4; i++) begin
            set_alu(5'd10, 0, {$urandom, $urandom});
            set_ld(5'(i + 1), 0, 64'(64'h100 + i));
            tick();
        end
        ld_valid = 0;
        chk("fifo_full", {63'd0, ld_ready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            set_alu(5'd11, 0, {$urandom, $urandom});
            tick();
        end
        idle();
        chk("proto_err_sticky", {63'd0, proto_err}, 64'd1);
        for (int i = 0; i < 5; i++) tick();

        // XZR discard and SP write.
        set_alu(5'd31, 0, 64'h55);
        tick();
        idle();
        chk("xzr_no_write", {63'd0, RegWrite}, 64'd0);
        set_alu(5'd31, 1, 64'h8000);
        tick();
        idle();
        chk("sp_we", {63'd0, RegWrite}, 64'd1);
        chk("sp_wr", {59'd0, Write_register}, 64'd31);
        chk("sp_wd", Write_d, 64'h8000);

        // Re-issue to x3 in the cycle its older load commits: pending bit stays set.
        set_issue(5'd3, 0);
        tick();
        idle();
        set_ld(5'd3, 0, 64'h33);
        tick();
        idle();
        tick();
        chk("x3_commit", {59'd0, Write_register}, 64'd3);
        set_issue(5'd3, 0);
        tick();
        idle();
        chk("busy3_set_wins", {63'd0, busy[3]}, 64'd1);
        tick();
        chk("busy3_held", {63'd0, busy[3]}, 64'd1);

        // Asynchronous reset with queued loads and pending registers.
        reset_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1;
        set_issue(5'd3, 0);
        tick();
        set_issue(5'd7, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_alu(5'd12, 0, {$urandom, $urandom});
            set_ld(5'd20, 0, {$urandom, $urandom});
            tick();
        end
        idle();
        chk("busy_before_reset", {32'd0, busy}, 64'h88);
        reset_n = 0;
        #1;
        model_reset();
        chk("reset_busy", {32'd0, busy}, 64'd0);
        chk("reset_regwrite", {63'd0, RegWrite}, 64'd0);
        check_all();
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("ready_after_reset", {63'd0, ld_ready}, 64'd1);
        @(negedge clk);

        // Randomized traffic: balanced, then ALU-heavy to provoke starvation.
        for (int i = 0; i < 300; i++) random_cycle(50);
        for (int i = 0; i < 300; i++) random_cycle(92);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
